memaccess: RTL and testbench

- MEM stage of PIGRO. Sits between execute and writeback.
- Registers the execute results into the writeback input bundle: aluoutput, loadmemorydata, cPC, destinationAddress, opcode.
- Performs LDW/STR against the data memory using a req/ack handshake. Stalls upstream for the duration of each access.
- Aborts an access that receives no ack within TIMEOUT cycles and flags the error.

---
 rtl/memaccess.sv | 122 ++++++++++++
 tb/tb_memaccess.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memaccess.sv
// PIGRO MEM stage: registers execute results into the writeback bundle and
// runs LDW/STR against data memory over a req/ack handshake with a timeout abort.
module memaccess #(
  parameter int DADDR_W = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [4:0]         in_opcode,
  input  logic [31:0]        in_aluout,
  input  logic [31:0]        in_storedata,
  input  logic [3:0]         in_destaddr,
  input  logic [4:0]         in_pc,
  output logic               stall,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_ack,
  output logic [31:0]        aluoutput,
  output logic [31:0]        loadmemorydata,
  output logic [4:0]         cPC,
  output logic [3:0]         destinationAddress,
  output logic [4:0]         opcode,
  output logic               mem_err
);

  // Opcode map: NOP=0, arithmetic/logic 1..ARSH, then the two memory ops.
  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ARSH = 5'd10;
  localparam logic [4:0] OP_LDW  = 5'd11;
  localparam logic [4:0] OP_STR  = 5'd12;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] cap_aluout;
  logic [4:0]  cap_pc;
  logic [3:0]  cap_dest;

  logic is_alu;
  logic is_mem;

  assign is_alu = (in_opcode > OP_NOP) && (in_opcode <= OP_ARSH);
  assign is_mem = (in_opcode == OP_LDW) || (in_opcode == OP_STR);

  // Stall is a pure decode of the state register, so it drops in the very
  // cycle after completion and upstream can issue again immediately.
  assign stall = (state == ACCESS);

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= 8'd0;
      dmem_req           <= 1'b0;
      dmem_we            <= 1'b0;
      dmem_addr          <= '0;
      dmem_wdata         <= 32'd0;
      aluoutput          <= 32'd0;
      loadmemorydata     <= 32'd0;
      cPC                <= 5'd0;
      destinationAddress <= 4'd0;
      opcode             <= OP_NOP;
      mem_err            <= 1'b0;
      cap_aluout         <= 32'd0;
      cap_pc             <= 5'd0;
      cap_dest           <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          opcode <= OP_NOP;
          if (in_valid && is_alu) begin
            aluoutput          <= in_aluout;
            loadmemorydata     <= 32'd0;
            cPC                <= in_pc;
            destinationAddress <= in_destaddr;
            opcode             <= in_opcode;
          end else if (in_valid && is_mem) begin
            state      <= ACCESS;
            cnt        <= 8'd0;
            dmem_req   <= 1'b1;
            dmem_we    <= (in_opcode == OP_STR);
            dmem_addr  <= in_aluout[DADDR_W-1:0];
            dmem_wdata <= in_storedata;
            cap_aluout <= in_aluout;
            cap_pc     <= in_pc;
            cap_dest   <= in_destaddr;
          end
        end

        ACCESS: begin
          opcode <= OP_NOP;
          cnt    <= cnt + 8'd1;
          // An ack on the last allowed cycle still completes the access.
          if (dmem_ack) begin
            state              <= IDLE;
            dmem_req           <= 1'b0;
            aluoutput          <= cap_aluout;
            loadmemorydata     <= dmem_we ? 32'd0 : dmem_rdata;
            cPC                <= cap_pc;
            destinationAddress <= cap_dest;
            opcode             <= dmem_we ? OP_STR : OP_LDW;
          end else if (cnt == CNT_LAST) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            mem_err  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memaccess.sv
// Self-checking bench for memaccess: scoreboard of expected writeback bundles
// plus per-scenario handshake and boundary checks.
module tb_memaccess;

  localparam int DADDR_W = 8;
  localparam int TIMEOUT = 15;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_ARSH = 5'd10;
  localparam logic [4:0] OP_LDW  = 5'd11;
  localparam logic [4:0] OP_STR  = 5'd12;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic [4:0]         in_opcode = 5'd0;
  logic [31:0]        in_aluout = 32'd0;
  logic [31:0]        in_storedata = 32'd0;
  logic [3:0]         in_destaddr = 4'd0;
  logic [4:0]         in_pc = 5'd0;
  logic               stall;
  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic [31:0]        dmem_rdata = 32'd0;
  logic               dmem_ack = 1'b0;
  logic [31:0]        aluoutput;
  logic [31:0]        loadmemorydata;
  logic [4:0]         cPC;
  logic [3:0]         destinationAddress;
  logic [4:0]         opcode;
  logic               mem_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [4:0]  pc;
    logic [3:0]  dest;
  } wb_t;

  wb_t sb[$];

  memaccess #(.DADDR_W(DADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_aluout(in_aluout), .in_storedata(in_storedata), .in_destaddr(in_destaddr),
    .in_pc(in_pc), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .aluoutput(aluoutput), .loadmemorydata(loadmemorydata),
    .cPC(cPC), .destinationAddress(destinationAddress), .opcode(opcode),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Every non-bubble writeback must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && opcode !== OP_NOP) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got op=%0d alu=%h ld=%h pc=%0d dest=%0d, expected bubble",
                 opcode, aluoutput, loadmemorydata, cPC, destinationAddress);
      end else begin
        wb_t e;
        e = sb.pop_front();
        if (opcode !== e.op || aluoutput !== e.alu || loadmemorydata !== e.ld ||
            cPC !== e.pc || destinationAddress !== e.dest) begin
          n_err++;
          $display("FAIL wb_bundle: got op=%0d alu=%h ld=%h pc=%0d dest=%0d, expected op=%0d alu=%h ld=%h pc=%0d dest=%0d",
                   opcode, aluoutput, loadmemorydata, cPC, destinationAddress,
                   e.op, e.alu, e.ld, e.pc, e.dest);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue_alu(input logic [4:0] op, input logic [31:0] a,
                           input logic [3:0] d, input logic [4:0] p, input bit expect_out);
    in_valid = 1'b1; in_opcode = op; in_aluout = a; in_destaddr = d; in_pc = p;
    in_storedata = $urandom;
    if (expect_out) sb.push_back('{op: op, alu: a, ld: 32'd0, pc: p, dest: d});
    step();
    in_valid = 1'b0;
  endtask

  // Issues LDW/STR, acks after `waits` wait cycles (never if waits >= TIMEOUT),
  // and checks the handshake every ACCESS cycle. Returns at the first non-stall negedge.
  task automatic run_mem(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input logic [3:0] d, input logic [4:0] p,
                         input int waits);
    bit complete = (waits < TIMEOUT);
    int exp_cycles = complete ? waits + 1 : TIMEOUT;
    int cycles = 0;
    logic [DADDR_W-1:0] exp_addr = a[DADDR_W-1:0];
    in_valid = 1'b1; in_opcode = op; in_aluout = a; in_storedata = wd;
    in_destaddr = d; in_pc = p;
    if (complete)
      sb.push_back('{op: op, alu: a, ld: (op == OP_LDW) ? rd : 32'd0, pc: p, dest: d});
    forever begin
      step();
      dmem_ack = 1'b0;
      if (!stall) break;
      cycles++;
      n_cmp++;
      if (dmem_req !== 1'b1 || dmem_we !== (op == OP_STR) || dmem_addr !== exp_addr ||
          dmem_wdata !== wd || opcode !== OP_NOP) begin
        n_err++;
        $display("FAIL access_hold cycle %0d: got req=%b we=%b addr=%h wdata=%h op=%0d, expected req=1 we=%b addr=%h wdata=%h op=0",
                 cycles, dmem_req, dmem_we, dmem_addr, dmem_wdata, opcode,
                 (op == OP_STR), exp_addr, wd);
      end
      // Upstream keeps presenting an instruction; it must be ignored while stalled.
      in_valid = 1'b1; in_opcode = OP_ADD; in_aluout = $urandom;
      if (cycles == waits + 1) begin
        dmem_ack = 1'b1; dmem_rdata = rd;
      end else begin
        dmem_rdata = $urandom;
      end
      if (cycles > TIMEOUT + 2) begin
        n_cmp++; n_err++;
        $display("FAIL access_bound: stall still high after %0d cycles, expected at most %0d",
                 cycles, exp_cycles);
        dmem_ack = 1'b0;
        break;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (cycles != exp_cycles || dmem_req !== 1'b0) begin
      n_err++;
      $display("FAIL access_len: got %0d stall cycles req=%b, expected %0d cycles req=0",
               cycles, dmem_req, exp_cycles);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({opcode, aluoutput, loadmemorydata, cPC, destinationAddress, dmem_addr,
         dmem_wdata, dmem_req, dmem_we, stall, mem_err} !== '0) begin
      n_err++;
      $display("FAIL %s: got op=%0d alu=%h ld=%h pc=%0d dest=%0d addr=%h wdata=%h req=%b we=%b stall=%b err=%b, expected all 0",
               name, opcode, aluoutput, loadmemorydata, cPC, destinationAddress,
               dmem_addr, dmem_wdata, dmem_req, dmem_we, stall, mem_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; dmem_ack = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    check_all_zero("reset_state");
  endtask

  task automatic test_alu();
    issue_alu(OP_ADD, 32'h0000_0007, 4'd3, 5'd4, 1'b1);
    n_cmp++;
    if (aluoutput !== 32'd7 || destinationAddress !== 4'd3 || cPC !== 5'd4 ||
        opcode !== OP_ADD || stall !== 1'b0) begin
      n_err++;
      $display("FAIL alu_add: got alu=%h dest=%0d pc=%0d op=%0d stall=%b, expected 7/3/4/1/0",
               aluoutput, destinationAddress, cPC, opcode, stall);
    end
    // NOP, invalid ADD, and an unknown opcode all produce bubbles and leave the bundle alone.
    issue_alu(OP_NOP, 32'h1111_1111, 4'd9, 5'd9, 1'b0);
    in_opcode = OP_ADD; in_aluout = 32'h2222_2222; in_valid = 1'b0;
    step();
    issue_alu(5'd25, 32'h3333_3333, 4'd8, 5'd8, 1'b0);
    n_cmp++;
    if (opcode !== OP_NOP || aluoutput !== 32'd7 || cPC !== 5'd4) begin
      n_err++;
      $display("FAIL alu_hold: got op=%0d alu=%h pc=%0d, expected op=0 alu=7 pc=4",
               opcode, aluoutput, cPC);
    end
  endtask

  task automatic test_back_to_back();
    issue_alu(OP_SUB,  32'hFFFF_0001, 4'd1, 5'd10, 1'b1);
    issue_alu(OP_XOR,  32'h8000_0000, 4'd2, 5'd11, 1'b1);
    issue_alu(OP_ARSH, 32'hC0DE_CAFE, 4'd15, 5'd31, 1'b1);
    run_mem(OP_LDW, 32'h0000_0033, 32'h0, 32'h0BAD_F00D, 4'd6, 5'd12, 1);
    // Next instruction goes in the very cycle stall drops.
    issue_alu(OP_ADD, 32'h0000_00AA, 4'd7, 5'd13, 1'b1);
    n_cmp++;
    if (opcode !== OP_ADD || aluoutput !== 32'h0000_00AA || stall !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_after_mem: got op=%0d alu=%h stall=%b, expected op=1 alu=aa stall=0",
               opcode, aluoutput, stall);
    end
  endtask

  task automatic test_ldw_immediate();
    run_mem(OP_LDW, 32'h0000_0012, 32'h0, 32'hDEAD_BEEF, 4'd5, 5'd6, 0);
    n_cmp++;
    if (opcode !== OP_LDW || loadmemorydata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL ldw_immediate: got op=%0d ld=%h, expected op=%0d ld=deadbeef",
               opcode, loadmemorydata, OP_LDW);
    end
  endtask

  task automatic test_str_wait();
    run_mem(OP_STR, 32'hABCD_0040, 32'h55AA_55AA, 32'h1234_5678, 4'd2, 5'd9, 3);
    n_cmp++;
    if (opcode !== OP_STR || loadmemorydata !== 32'd0 || aluoutput !== 32'hABCD_0040) begin
      n_err++;
      $display("FAIL str_wait: got op=%0d ld=%h alu=%h, expected op=%0d ld=0 alu=abcd0040",
               opcode, loadmemorydata, aluoutput, OP_STR);
    end
  endtask

  task automatic test_ack_at_limit();
    run_mem(OP_LDW, 32'h7700_00FF, 32'h0, 32'hFACE_0001, 4'd4, 5'd20, TIMEOUT - 1);
    n_cmp++;
    if (mem_err !== 1'b0 || opcode !== OP_LDW) begin
      n_err++;
      $display("FAIL ack_at_limit: got err=%b op=%0d, expected err=0 op=%0d",
               mem_err, opcode, OP_LDW);
    end
  endtask

  task automatic test_timeout();
    run_mem(OP_LDW, 32'h0000_0080, 32'h0, 32'h0, 4'd3, 5'd21, TIMEOUT + 5);
    n_cmp++;
    if (mem_err !== 1'b1 || opcode !== OP_NOP) begin
      n_err++;
      $display("FAIL timeout_abort: got err=%b op=%0d, expected err=1 op=0", mem_err, opcode);
    end
    issue_alu(OP_ADD, 32'h0000_0001, 4'd1, 5'd22, 1'b1);
    step();
    n_cmp++;
    if (mem_err !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_sticky: got err=%b, expected err=1", mem_err);
    end
  endtask

  task automatic test_idle_ack();
    dmem_ack = 1'b1; dmem_rdata = 32'h9999_9999;
    step();
    dmem_ack = 1'b0;
    step();
    n_cmp++;
    if (stall !== 1'b0 || dmem_req !== 1'b0 || loadmemorydata !== 32'd0 || opcode !== OP_NOP) begin
      n_err++;
      $display("FAIL idle_ack: got stall=%b req=%b ld=%h op=%0d, expected 0/0/0/0",
               stall, dmem_req, loadmemorydata, opcode);
    end
  endtask

  task automatic test_reset_mid_access();
    in_valid = 1'b1; in_opcode = OP_LDW; in_aluout = 32'h0000_0044;
    in_destaddr = 4'd9; in_pc = 5'd17;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("reset_mid_access");
    dmem_ack = 1'b1; dmem_rdata = 32'hBEEF_BEEF;
    step();
    dmem_ack = 1'b0;
    check_all_zero("late_ack_ignored");
    step();
    check_all_zero("late_ack_settled");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ldw_immediate();
    test_str_wait();
    test_back_to_back();
    test_ack_at_limit();
    test_timeout();
    test_idle_ack();
    test_reset_mid_access();
    repeat (2) step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d outstanding writebacks, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
